q_episode_sequencer: RTL and testbench

- Controls Q-learning training and exploit runs on the 6x6 maze (states 1..36).
- Per step: reads the Q row for the current state, picks an action (epsilon-greedy), hands it to the maze step unit, waits for its completion strobe, and tracks episode and step counts.
- Sits between the Q-table storage and the maze step unit. Terminates episodes on reaching the target or on a step limit.

---
 rtl/q_episode_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_q_episode_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_episode_sequencer.sv
// Q-learning episode sequencer for the 6x6 maze (cells 1..36).
// Reads the Q row of the current cell, picks an epsilon-greedy action, hands it to the
// maze step unit, and tracks step/episode counts until the run of episodes completes.
// Optional feature macro: Q_EPS_DECAY_EN (per-episode decaying exploration threshold).
module q_episode_sequencer #(
  parameter int unsigned NUM_EPISODES = 100,
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned EPS_THRESH   = 26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic [5:0]   start_state_i,
  input  logic [5:0]   target_state_i,
  output logic [5:0]   q_rd_state_o,
  input  logic [127:0] q_rd_data_i,
  output logic         step_req_o,
  output logic [1:0]   step_action_o,
  output logic [5:0]   step_state_o,
  input  logic         step_ack_i,
  input  logic [5:0]   step_next_state_i,
  output logic [5:0]   cur_state_o,
  output logic [15:0]  episode_count_o,
  output logic [7:0]   step_count_o,
  output logic         busy_o,
  output logic         episode_done_o,
  output logic         goal_reached_o,
  output logic         run_done_o
);

  localparam logic [15:0] NumEp    = 16'(NUM_EPISODES);
  localparam logic [7:0]  MaxSteps = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    StIdle, StInit, StRead, StChoose, StIssue, StWait, StCheck
  } state_e;

  state_e       state_q;
  logic [15:0]  lfsr_q;
  logic [5:0]   target_q;
  logic [5:0]   q_rd_state_q;
  logic         step_req_q;
  logic [1:0]   step_action_q;
  logic [5:0]   step_state_q;
  logic [5:0]   cur_state_q;
  logic [15:0]  episode_count_q;
  logic [7:0]   step_count_q;
  logic         busy_q;
  logic         episode_done_q;
  logic         goal_reached_q;
  logic         run_done_q;

  logic [15:0]  lfsr_d;
  logic [1:0]   greedy_action;
  logic [8:0]   thresh;
  logic         explore;
  logic [15:0]  episode_count_inc;

`ifdef Q_EPS_DECAY_EN
  logic [8:0]   eps_q;
  assign thresh = eps_q;
`else
  assign thresh = 9'(EPS_THRESH);
`endif

  // Right-shifting Galois LFSR, taps 16,14,13,11.
  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign explore = ({1'b0, lfsr_q[7:0]} < thresh);
  assign episode_count_inc = episode_count_q + 16'd1;

  // Signed argmax over the Q row; strict compare keeps the lowest index on ties.
  always_comb begin
    logic signed [31:0] best_val;
    logic signed [31:0] cand;
    best_val      = signed'(q_rd_data_i[31:0]);
    greedy_action = 2'd0;
    for (int i = 1; i < 4; i++) begin
      cand = signed'(q_rd_data_i[32*i +: 32]);
      if (cand > best_val) begin
        best_val      = cand;
        greedy_action = 2'(i);
      end
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      lfsr_q          <= LFSR_SEED;
      target_q        <= 6'd0;
      q_rd_state_q    <= 6'd0;
      step_req_q      <= 1'b0;
      step_action_q   <= 2'd0;
      step_state_q    <= 6'd0;
      cur_state_q     <= 6'd0;
      episode_count_q <= 16'd0;
      step_count_q    <= 8'd0;
      busy_q          <= 1'b0;
      episode_done_q  <= 1'b0;
      goal_reached_q  <= 1'b0;
      run_done_q      <= 1'b0;
`ifdef Q_EPS_DECAY_EN
      eps_q           <= 9'd0;
`endif
    end else begin
      episode_done_q <= 1'b0;
      goal_reached_q <= 1'b0;
      run_done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run_i) begin
            target_q        <= target_state_i;
            episode_count_q <= 16'd0;
            busy_q          <= 1'b1;
            state_q         <= StInit;
`ifdef Q_EPS_DECAY_EN
            eps_q           <= 9'(EPS_THRESH);
`endif
          end
        end
        StInit: begin
          cur_state_q  <= start_state_i;
          q_rd_state_q <= start_state_i;
          step_count_q <= 8'd0;
          state_q      <= StRead;
        end
        StRead: begin
          q_rd_state_q <= cur_state_q;
          state_q      <= StChoose;
        end
        StChoose: begin
          step_action_q <= explore ? lfsr_q[9:8] : greedy_action;
          lfsr_q        <= lfsr_d;
          state_q       <= StIssue;
        end
        StIssue: begin
          step_req_q   <= 1'b1;
          step_state_q <= cur_state_q;
          state_q      <= StWait;
        end
        StWait: begin
          if (step_ack_i) begin
            cur_state_q  <= step_next_state_i;
            q_rd_state_q <= step_next_state_i;
            if (step_count_q != 8'hFF) step_count_q <= step_count_q + 8'd1;
            step_req_q   <= 1'b0;
            state_q      <= StCheck;
          end
        end
        StCheck: begin
          if ((cur_state_q == target_q) || (step_count_q == MaxSteps)) begin
            episode_done_q  <= 1'b1;
            goal_reached_q  <= (cur_state_q == target_q);
            episode_count_q <= episode_count_inc;
`ifdef Q_EPS_DECAY_EN
            if (eps_q != 9'd0) eps_q <= eps_q - 9'd1;
`endif
            if (episode_count_inc == NumEp) begin
              run_done_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end else begin
              state_q <= StInit;
            end
          end else begin
            state_q <= StRead;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign q_rd_state_o    = q_rd_state_q;
  assign step_req_o      = step_req_q;
  assign step_action_o   = step_action_q;
  assign step_state_o    = step_state_q;
  assign cur_state_o     = cur_state_q;
  assign episode_count_o = episode_count_q;
  assign step_count_o    = step_count_q;
  assign busy_o          = busy_q;
  assign episode_done_o  = episode_done_q;
  assign goal_reached_o  = goal_reached_q;
  assign run_done_o      = run_done_q;

endmodule

// File: tb/tb_q_episode_sequencer.sv
// Scoreboard bench for q_episode_sequencer: a greedy instance (EPS_THRESH=0) driven
// through several directed runs, plus an exploring instance checked against an LFSR model.
module tb_q_episode_sequencer;

  logic         clk;
  logic         rst;
  logic         run;
  logic [5:0]   start_state;
  logic [5:0]   target_state;
  logic [5:0]   q_rd_state;
  logic [127:0] q_rd_data;
  logic         step_req;
  logic [1:0]   step_action;
  logic [5:0]   step_state;
  logic         step_ack;
  logic [5:0]   step_next_state;
  logic [5:0]   cur_state;
  logic [15:0]  episode_count;
  logic [7:0]   step_count;
  logic         busy;
  logic         episode_done;
  logic         goal_reached;
  logic         run_done;

  // Exploring instance signals
  logic         x_run;
  logic [5:0]   x_q_rd_state;
  logic [127:0] x_q_rd_data;
  logic         x_step_req;
  logic [1:0]   x_step_action;
  logic [5:0]   x_step_state;
  logic         x_step_ack;
  logic [5:0]   x_cur_state;
  logic [15:0]  x_episode_count;
  logic [7:0]   x_step_count;
  logic         x_busy;
  logic         x_episode_done;
  logic         x_goal_reached;
  logic         x_run_done;

  q_episode_sequencer #(
    .NUM_EPISODES(3), .MAX_STEPS(4), .EPS_THRESH(0), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .run_i(run),
    .start_state_i(start_state), .target_state_i(target_state),
    .q_rd_state_o(q_rd_state), .q_rd_data_i(q_rd_data),
    .step_req_o(step_req), .step_action_o(step_action), .step_state_o(step_state),
    .step_ack_i(step_ack), .step_next_state_i(step_next_state),
    .cur_state_o(cur_state), .episode_count_o(episode_count), .step_count_o(step_count),
    .busy_o(busy), .episode_done_o(episode_done), .goal_reached_o(goal_reached),
    .run_done_o(run_done)
  );

  q_episode_sequencer #(
    .NUM_EPISODES(1), .MAX_STEPS(6), .EPS_THRESH(128), .LFSR_SEED(16'hACE1)
  ) u_exp (
    .clk_i(clk), .rst_i(rst), .run_i(x_run),
    .start_state_i(6'd5), .target_state_i(6'd36),
    .q_rd_state_o(x_q_rd_state), .q_rd_data_i(x_q_rd_data),
    .step_req_o(x_step_req), .step_action_o(x_step_action), .step_state_o(x_step_state),
    .step_ack_i(x_step_ack), .step_next_state_i(x_step_state),
    .cur_state_o(x_cur_state), .episode_count_o(x_episode_count),
    .step_count_o(x_step_count), .busy_o(x_busy), .episode_done_o(x_episode_done),
    .goal_reached_o(x_goal_reached), .run_done_o(x_run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Q-table model, synchronous read
  logic [127:0] qmem [0:63];
  always @(posedge clk) q_rd_data <= qmem[q_rd_state];
  assign x_q_rd_data = '0;

  // Step unit model for the greedy instance
  int   ack_delay = 0;
  logic blocked   = 1'b0;
  int   ack_cnt   = 0;
  always @(negedge clk) begin
    if (rst) begin
      step_ack = 1'b0;
      ack_cnt  = 0;
    end else if (step_ack) begin
      step_ack = 1'b0;
    end else if (step_req) begin
      if (ack_cnt >= ack_delay) begin
        step_ack = 1'b1;
        ack_cnt  = 0;
        if (blocked) step_next_state = step_state;
        else case (step_action)
          2'd0: step_next_state = step_state + 6'd6;
          2'd1: step_next_state = step_state + 6'd1;
          2'd2: step_next_state = step_state - 6'd6;
          default: step_next_state = step_state - 6'd1;
        endcase
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Step unit for the exploring instance: always blocked, acks on first sighting
  always @(negedge clk) begin
    if (rst || x_step_ack) x_step_ack = 1'b0;
    else if (x_step_req) x_step_ack = 1'b1;
  end

  typedef struct {logic [1:0] act; logic [5:0] st;} step_t;
  typedef struct {logic goal; logic [7:0] steps; logic [15:0] cnt; logic rd;} ep_t;
  step_t exp_step_q[$];
  ep_t   exp_ep_q[$];
  logic [1:0] x_exp_q[$];
  int    x_ep_seen = 0;

  // Monitor: pops expectations as the DUTs present requests / episode ends
  logic  req_prev   = 1'b0;
  logic  x_req_prev = 1'b0;
  step_t cur_step;
  ep_t   cur_ep;
  always @(negedge clk) begin
    if (step_req) begin
      if (!req_prev) begin
        if (exp_step_q.size() == 0) miss("step_unexpected");
        else cur_step = exp_step_q.pop_front();
      end
      chk("step_action", 32'(step_action), 32'(cur_step.act));
      chk("step_state", 32'(step_state), 32'(cur_step.st));
    end
    req_prev <= step_req;
    if (episode_done) begin
      if (exp_ep_q.size() == 0) miss("episode_unexpected");
      else begin
        cur_ep = exp_ep_q.pop_front();
        chk("goal_reached", 32'(goal_reached), 32'(cur_ep.goal));
        chk("ep_step_count", 32'(step_count), 32'(cur_ep.steps));
        chk("episode_count", 32'(episode_count), 32'(cur_ep.cnt));
        chk("run_done", 32'(run_done), 32'(cur_ep.rd));
      end
    end else if (run_done) begin
      miss("run_done_without_episode");
    end
    if (x_step_req && !x_req_prev) begin
      if (x_exp_q.size() == 0) miss("x_step_unexpected");
      else chk("x_step_action", 32'(x_step_action), 32'(x_exp_q.pop_front()));
    end
    x_req_prev <= x_step_req;
    if (x_episode_done) begin
      x_ep_seen++;
      chk("x_goal_reached", 32'(x_goal_reached), 32'd0);
      chk("x_step_count", 32'(x_step_count), 32'd6);
      chk("x_run_done", 32'(x_run_done), 32'd1);
    end
  end

  task automatic push_run(input logic [5:0] st, input logic [1:0] act,
                          input int nsteps, input logic goal);
    for (int e = 1; e <= 3; e++) begin
      for (int s = 0; s < nsteps; s++) exp_step_q.push_back('{act: act, st: st});
      exp_ep_q.push_back('{goal: goal, steps: 8'(nsteps), cnt: 16'(e), rd: (e == 3)});
    end
  endtask

  task automatic start_run(input logic [5:0] s, input logic [5:0] t);
    @(negedge clk);
    start_state  = s;
    target_state = t;
    run          = 1'b1;
    @(negedge clk);
    run          = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (run_done) found = 1'b1;
    end
    if (!found) miss(name);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_final_count"}, 32'(episode_count), 32'd3);
    chk({name, "_steps_left"}, 32'(exp_step_q.size()), 32'd0);
    chk({name, "_eps_left"}, 32'(exp_ep_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] lfsr;
    logic        found;
    rst = 1'b1; run = 1'b0; x_run = 1'b0;
    start_state = 6'd0; target_state = 6'd0;
    step_ack = 1'b0; step_next_state = 6'd0; x_step_ack = 1'b0;
    for (int i = 0; i < 64; i++) qmem[i] = '0;

    // Exploring instance: threshold 128, Q row all zero so exploit picks action 0
    lfsr = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      x_exp_q.push_back((lfsr[7:0] < 8'd128) ? lfsr[9:8] : 2'd0);
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step_req", 32'(step_req), 32'd0);
    chk("rst_cur_state", 32'(cur_state), 32'd0);
    chk("rst_episode_count", 32'(episode_count), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    chk("rst_q_rd_state", 32'(q_rd_state), 32'd0);
    chk("rst_done_flags", 32'({episode_done, goal_reached, run_done}), 32'd0);
    rst = 1'b0;
    x_run = 1'b1;
    @(negedge clk);
    x_run = 1'b0;

    // Run A: greedy one-step episodes 1 -> 7 (Q0 largest)
    qmem[1] = {32'd0, 32'd0, 32'd0, 32'd5};
    ack_delay = 0; blocked = 1'b0;
    push_run(6'd1, 2'd0, 1, 1'b1);
    start_run(6'd1, 6'd7);
    wait_done("runA", 500);

    // Run D: signed argmax with a tie between Q1 and Q2 -> action 1, 1 -> 2
    qmem[1] = {32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFB};
    ack_delay = 2;
    push_run(6'd1, 2'd1, 1, 1'b1);
    start_run(6'd1, 6'd2);
    wait_done("runD", 500);

    // Run B: all-equal row, blocked moves, 10+ cycle ack delay, step limit 4
    qmem[2] = {4{32'd7}};
    ack_delay = 10; blocked = 1'b1;
    push_run(6'd2, 2'd0, 4, 1'b0);
    start_run(6'd2, 6'd30);
    repeat (30) @(negedge clk);
    run = 1'b1;  // must be ignored while busy
    @(negedge clk);
    run = 1'b0;
    wait_done("runB", 3000);

    // Run C: reset while waiting for an ack
    ack_delay = 500;
    exp_step_q.push_back('{act: 2'd0, st: 6'd3});
    start_run(6'd3, 6'd33);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (step_req) found = 1'b1;
    end
    if (!found) miss("runC_step_req_timeout");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_step_req", 32'(step_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_episode_count", 32'(episode_count), 32'd0);
    chk("abort_step_count", 32'(step_count), 32'd0);
    chk("abort_episode_done", 32'(episode_done), 32'd0);
    rst = 1'b0;
    chk("abort_steps_left", 32'(exp_step_q.size()), 32'd0);

    // Run A again: clean restart after the abort
    qmem[1] = {32'd0, 32'd0, 32'd0, 32'd5};
    ack_delay = 1; blocked = 1'b0;
    push_run(6'd1, 2'd0, 1, 1'b1);
    start_run(6'd1, 6'd7);
    wait_done("restart", 500);

    chk("x_episodes_seen", 32'(x_ep_seen), 32'd1);
    chk("x_actions_left", 32'(x_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
